// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM fader: colour palette, fader states
// and the 8-bit to PWM-width colour expansion.
package rgb_pwm_pkg;

    localparam int PALETTE_SIZE = 8;
    localparam int NUM_CH       = 3;
    localparam int CH_R         = 0;
    localparam int CH_G         = 1;
    localparam int CH_B         = 2;

    // One palette entry viewed as its three 8-bit components.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Entry 0 sits in the lowest 24 bits, so PALETTE[i] is button index i.
    localparam logic [PALETTE_SIZE-1:0][23:0] PALETTE = {
        24'h000000,   // 7 black
        24'h8000FF,   // 6 violet
        24'h4B0082,   // 5 indigo
        24'h0000FF,   // 4 blue
        24'h00FF00,   // 3 green
        24'hFFFF00,   // 2 yellow
        24'hFF8000,   // 1 orange
        24'hFF0000    // 0 red
    };

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

    // Widens an 8-bit component by repeating its bits, so 00 stays zero and
    // FF becomes all ones at any PWM width up to 16 bits.
    function automatic logic [15:0] expand_component(input logic [7:0] c, input int pwmW);
        logic [15:0] rep;
        rep = {c, c};
        return rep >> (16 - pwmW);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM counter with end-of-period and fade-step strobes.
module pwm_period_counter #(
    parameter int PWM_W        = 8,
    parameter int STEP_PERIODS = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [PWM_W-1:0] o_cnt,
    output logic             o_periodTick,
    output logic             o_stepTick
);

    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    logic [PWM_W-1:0]  r_cnt;
    logic [STEP_W-1:0] r_stepCnt;

    // PWM counter wraps naturally at its full width, one period per wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWM_W'(1);
        end
    end

    // Counts whole periods so fade steps land on a fixed phase regardless of button timing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stepCnt <= '0;
        end else if (o_periodTick) begin
            r_stepCnt <= (r_stepCnt == STEP_LAST) ? '0 : r_stepCnt + STEP_W'(1);
        end
    end

    assign o_cnt        = r_cnt;
    assign o_periodTick = (r_cnt == '1);
    assign o_stepTick   = o_periodTick && (r_stepCnt == STEP_LAST);

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED PWM controller: picks a palette colour from the buttons and ramps
// each channel's duty toward it in bounded steps at period boundaries.
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_W        = 8,
    parameter int NUM_LED      = 4,
    parameter int NUM_BTN      = 8,
    parameter int FADE_STEP    = 1,
    parameter int STEP_PERIODS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_LED-1:0] led_signal_R,
    output logic [NUM_LED-1:0] led_signal_G,
    output logic [NUM_LED-1:0] led_signal_B,
    output logic               busy,
    output logic               period_tick
);

    localparam logic signed [PWM_W:0] STEP_S = (PWM_W+1)'(FADE_STEP);

    logic [PWM_W-1:0] w_cnt;
    logic             w_periodTick;
    logic             w_stepTick;

    logic [2:0]       w_btnIdx;
    logic             w_btnAny;
    rgb8_t            w_entry;
    logic [PWM_W-1:0] w_select [NUM_CH];

    logic [PWM_W-1:0] r_target  [NUM_CH];
    logic [PWM_W-1:0] r_current [NUM_CH];
    logic [PWM_W-1:0] r_applied [NUM_CH];

    logic signed [PWM_W:0] w_diff [NUM_CH];
    logic signed [PWM_W:0] w_mag  [NUM_CH];
    logic signed [PWM_W:0] w_amt  [NUM_CH];
    logic [PWM_W-1:0]      w_next [NUM_CH];
    logic [PWM_W-1:0]      w_post [NUM_CH];
    logic                  w_allDone;
    logic                  w_differ;
    logic                  w_doStep;

    fade_state_t r_state;
    fade_state_t w_nextState;

    logic [NUM_LED-1:0] r_ledR;
    logic [NUM_LED-1:0] r_ledG;
    logic [NUM_LED-1:0] r_ledB;

    pwm_period_counter #(
        .PWM_W        (PWM_W),
        .STEP_PERIODS (STEP_PERIODS)
    ) u_periodCounter (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_cnt        (w_cnt),
        .o_periodTick (w_periodTick),
        .o_stepTick   (w_stepTick)
    );

    // Lowest pressed button wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        w_btnIdx = '0;
        w_btnAny = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (btn[i]) begin
                w_btnIdx = 3'(i);
                w_btnAny = 1'b1;
            end
        end
    end

    // Palette lookup widened to the PWM resolution.
    always_comb begin
        w_entry        = rgb8_t'(PALETTE[w_btnIdx]);
        w_select[CH_R] = PWM_W'(expand_component(w_entry.r, PWM_W));
        w_select[CH_G] = PWM_W'(expand_component(w_entry.g, PWM_W));
        w_select[CH_B] = PWM_W'(expand_component(w_entry.b, PWM_W));
    end

    // Per-channel step toward target, clamped to the remaining distance so it never overshoots.
    always_comb begin
        w_allDone = 1'b1;
        w_differ  = 1'b0;
        w_doStep  = (r_state == FADE) && w_stepTick;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_diff[ch] = $signed({1'b0, r_target[ch]}) - $signed({1'b0, r_current[ch]});
            w_mag[ch]  = (w_diff[ch] < 0) ? -w_diff[ch] : w_diff[ch];
            w_amt[ch]  = (w_mag[ch] > STEP_S) ? STEP_S : w_mag[ch];
            if (w_diff[ch] < 0) begin
                w_next[ch] = r_current[ch] - PWM_W'(w_amt[ch]);
            end else begin
                w_next[ch] = r_current[ch] + PWM_W'(w_amt[ch]);
            end
            w_post[ch] = w_doStep ? w_next[ch] : r_current[ch];
            if (w_next[ch] != r_target[ch]) begin
                w_allDone = 1'b0;
            end
            if (r_target[ch] != r_current[ch]) begin
                w_differ = 1'b1;
            end
        end
    end

    // Fader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Enter FADE on any mismatch; leave only once a step lands every channel on target.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_differ) w_nextState = FADE;
            FADE:    if (w_stepTick && w_allDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Target follows the buttons, current follows fade steps, applied only changes between periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_target[ch]  <= '0;
                r_current[ch] <= '0;
                r_applied[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_btnAny) begin
                    r_target[ch] <= w_select[ch];
                end
                if (w_doStep) begin
                    r_current[ch] <= w_next[ch];
                end
                if (w_periodTick) begin
                    r_applied[ch] <= w_post[ch];
                end
            end
        end
    end

    // Registered PWM compare keeps the LED pins free of combinational glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ledR <= '0;
            r_ledG <= '0;
            r_ledB <= '0;
        end else begin
            r_ledR <= {NUM_LED{w_cnt < r_applied[CH_R]}};
            r_ledG <= {NUM_LED{w_cnt < r_applied[CH_G]}};
            r_ledB <= {NUM_LED{w_cnt < r_applied[CH_B]}};
        end
    end

    assign led_signal_R = r_ledR;
    assign led_signal_G = r_ledG;
    assign led_signal_B = r_ledB;
    assign busy         = (r_state == FADE);
    assign period_tick  = w_periodTick;

endmodule
